// File: rtl/ram_arbiter.sv
// ram_arbiter: two-master arbiter for a single-port word RAM with byte-write read-modify-write
//   clk, rst (async active-low)
//   m_req_i/m_we_i[1:0], m0_/m1_addr_i, m0_/m1_wdata_i, m0_/m1_sel_i : master requests
//   m_gnt_o[1:0] (combinational), m_rvalid_o[1:0], m_rdata_o           : grant and response
//   ram_we_o, ram_addr_o, ram_wdata_o, ram_rdata_i                      : RAM side
module ram_arbiter #(
    parameter bit RR_EN  = 1'b1,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        m_req_i,
    input  logic [1:0]        m_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic [DATA_W/8-1:0] m0_sel_i,
    input  logic [DATA_W/8-1:0] m1_sel_i,
    output logic [1:0]        m_gnt_o,
    output logic [1:0]        m_rvalid_o,
    output logic [DATA_W-1:0] m_rdata_o,
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    localparam int NB = DATA_W / 8;
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] RMW_WR = 1'b1;
    logic [0:0]        state_q;
    logic              last_q;
    logic              cap_k_q;
    logic [ADDR_W-1:0] cap_addr_q;
    logic [DATA_W-1:0] cap_wdata_q;
    logic [DATA_W-1:0] cap_old_q;
    logic [NB-1:0]     cap_sel_q;
    logic              win1;
    logic              k;
    logic              go;
    logic              we;
    logic              full;
    logic              zero;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [NB-1:0]     sel;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] merged;
    always_comb begin
        // m1 wins when alone, or on a tie when round-robin says it is m1's turn
        win1   = m_req_i[1] & (~m_req_i[0] | (RR_EN & ~last_q));
        gnt    = (rst && state_q == IDLE) ? (win1 ? 2'b10 : {1'b0, m_req_i[0]}) : 2'b00;
        k      = gnt[1];
        go     = |gnt;
        addr   = k ? m1_addr_i : m0_addr_i;
        wdata  = k ? m1_wdata_i : m0_wdata_i;
        sel    = k ? m1_sel_i : m0_sel_i;
        we     = m_we_i[k];
        full   = &sel;
        zero   = ~|sel;
        mask   = '0;
        for (int i = 0; i < NB; i++) mask[8*i +: 8] = {8{cap_sel_q[i]}};
        merged = (cap_wdata_q & mask) | (cap_old_q & ~mask);
        m_gnt_o     = gnt;
        ram_we_o    = rst & (state_q == RMW_WR | (go & we & full));
        ram_addr_o  = !rst ? '0 : state_q == RMW_WR ? cap_addr_q : addr;
        ram_wdata_o = !rst ? '0 : state_q == RMW_WR ? merged : wdata;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            cap_k_q     <= 1'b0;
            cap_addr_q  <= '0;
            cap_wdata_q <= '0;
            cap_old_q   <= '0;
            cap_sel_q   <= '0;
            m_rvalid_o  <= 2'b00;
            m_rdata_o   <= '0;
        end else if (state_q == RMW_WR) begin
            state_q    <= IDLE;
            m_rvalid_o <= cap_k_q ? 2'b10 : 2'b01;
            m_rdata_o  <= '0;
        end else if (go) begin
            last_q <= k;
            // partial writes latch the old word now and write the merged word next cycle
            if (we && !full && !zero) begin
                state_q     <= RMW_WR;
                cap_k_q     <= k;
                cap_addr_q  <= addr;
                cap_wdata_q <= wdata;
                cap_sel_q   <= sel;
                cap_old_q   <= ram_rdata_i;
                m_rvalid_o  <= 2'b00;
            end else begin
                m_rvalid_o <= gnt;
                m_rdata_o  <= we ? '0 : ram_rdata_i;
            end
        end else begin
            m_rvalid_o <= 2'b00;
        end
    end
endmodule
